sr_latch_sequencer: RTL

Controller in front of the SR latch network. It arbitrates among NREQ requesters that want to read, set, reset or toggle one of NLAT SR latches. It generates properly timed, never-overlapping S/R drive pulses, waits for the latches to settle, and then reads each latch back to confirm the result. Requesters never touch S/R lines directly; this block is the only driver of the latch bank.

---
 rtl/sr_latch_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sr_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_sequencer
// Description : Round-robin arbitrated controller for a bank of SR latches.
//               Issues non-overlapping S/R drive pulses, waits for the latch
//               to settle, then reads it back and flags mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_sequencer #(
  parameter int NREQ   = 4,
  parameter int NLAT   = 8,
  parameter int IDXW   = 3,
  parameter int PULSE  = 2,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [IDXW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic                   done,
  output logic                   rd_val,
  output logic                   err,
  output logic                   busy,
  output logic [NLAT-1:0]        latch_s,
  output logic [NLAT-1:0]        latch_r,
  input  logic [NLAT-1:0]        latch_q
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NPAD = 1 << IDXW;
  localparam int CMAX = (PULSE > SETTLE) ? PULSE : SETTLE;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0]      c_op_read   = 2'b00;
  localparam logic [1:0]      c_op_set    = 2'b01;
  localparam logic [1:0]      c_op_reset  = 2'b10;
  localparam logic [CNTW-1:0] c_pulse_m1  = CNTW'(PULSE - 1);
  localparam logic [CNTW-1:0] c_settle_m1 = CNTW'(SETTLE - 1);
  localparam logic [PTRW-1:0] c_last_req  = PTRW'(NREQ - 1);
  localparam logic [IDXW:0]   c_nlat      = (IDXW + 1)'(NLAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CNTW-1:0] r_cnt, w_cnt_nx;
  logic [PTRW-1:0] r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [IDXW-1:0] r_idx;
  logic            r_set;    // resolved direction: 1 = SET, 0 = RESET
  logic            r_read;
  logic            r_oor;

  logic            w_found;
  logic            w_capture;
  logic [PTRW-1:0] w_winner;
  logic [1:0]      w_win_op;
  logic [IDXW-1:0] w_win_idx;
  logic            w_win_oor;
  logic            w_win_read;
  logic            w_win_set;
  logic [NPAD-1:0] w_q_pad;
  logic [NPAD-1:0] w_onehot;
  logic            w_q_now;

  // Zero-extend the latch outputs so any index value selects a defined bit.
  assign w_q_pad  = NPAD'(latch_q);
  assign w_onehot = NPAD'(1) << r_idx;
  assign w_q_now  = w_q_pad[r_idx];

  // Round-robin search: first active request at or after the pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = PTRW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Decode the winner's command; TOGGLE is resolved against the current Q.
  always_comb begin
    w_win_op   = op[w_winner*2 +: 2];
    w_win_idx  = idx[w_winner*IDXW +: IDXW];
    w_win_oor  = ({1'b0, w_win_idx} >= c_nlat);
    w_win_read = (w_win_op == c_op_read);
    if (w_win_op == c_op_set)
      w_win_set = 1'b1;
    else if (w_win_op == c_op_reset)
      w_win_set = 1'b0;
    else
      w_win_set = ~w_q_pad[w_win_idx];
  end

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state logic; READ and out-of-range commands bypass DRIVE.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_capture = 1'b1;
          if (w_win_read || w_win_oor) begin
            w_state_nx = S_SETTLE;
            w_cnt_nx   = c_settle_m1;
          end else begin
            w_state_nx = S_DRIVE;
            w_cnt_nx   = c_pulse_m1;
          end
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nx = S_SETTLE;
          w_cnt_nx   = c_settle_m1;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0)
          w_state_nx = S_RESP;
        else
          w_cnt_nx = r_cnt - 1'b1;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Capture the winning command, advance the pointer and raise its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_idx  <= '0;
      r_set  <= 1'b0;
      r_read <= 1'b0;
      r_oor  <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_capture) begin
        r_ptr  <= (w_winner == c_last_req) ? '0 : w_winner + 1'b1;
        r_gnt  <= NREQ'(1) << w_winner;
        r_idx  <= w_win_idx;
        r_set  <= w_win_set;
        r_read <= w_win_read;
        r_oor  <= w_win_oor;
      end
    end
  end

  // Outputs are decoded from state so reset clears every drive immediately.
  always_comb begin
    gnt     = r_gnt;
    busy    = (r_state != S_IDLE);
    latch_s = '0;
    latch_r = '0;
    done    = 1'b0;
    rd_val  = 1'b0;
    err     = 1'b0;
    if (r_state == S_DRIVE) begin
      if (r_set)
        latch_s = w_onehot[NLAT-1:0];
      else
        latch_r = w_onehot[NLAT-1:0];
    end
    if (r_state == S_RESP) begin
      done   = 1'b1;
      rd_val = ~r_oor & w_q_now;
      if (r_oor)
        err = 1'b1;
      else if (!r_read)
        err = r_set ? ~w_q_now : w_q_now;
    end
  end

endmodule
`default_nettype wire
